jtkcpu_busarb: RTL and testbench

//  Shares the external memory bus between the jtkcpu core and one DMA requester
//  (e.g. sprite/palette copy engine). Owns chip-select and wait-state sequencing

---
 rtl/jtkcpu_busarb.sv | 176 +++++++++++++++++
 tb/tb_jtkcpu_busarb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_busarb.sv
`timescale 1ns/1ps
// jtkcpu_busarb
// Shares one external memory bus between the jtkcpu core and a single DMA
// requester. Sequences chip select against mem_dtack, halts the CPU while DMA
// owns the bus, limits DMA bursts so the CPU cannot starve, and aborts any
// access whose dtack never arrives.
//
// Ports
//   clk, rst_n, cen                  clock, async active-low reset, clock enable
//   cpu_req/we/addr/dout -> cpu_din  CPU access request, read data
//   cpu_ack, cpu_halt                CPU completion pulse, CPU halt
//   dma_req/we/addr/dout -> dma_din  DMA access request, read data
//   dma_ack                          DMA completion pulse
//   mem_cs/we/addr/dout, mem_din     memory bus
//   mem_dtack                        memory access complete
//   bus_err                          sticky watchdog timeout flag
//
// state | meaning
// IDLE  | bus free, arbitrate between CPU and DMA
// HOLD  | one dead tick so the CPU reaches its halt point before DMA drives
// CPU   | CPU access in progress, waiting for dtack
// DMA   | DMA access in progress, waiting for dtack
module jtkcpu_busarb #(
  parameter int AW      = 24,
  parameter int DMA_MAX = 16,
  parameter int TOUT    = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    cpu_din,
  output logic          cpu_ack,
  output logic          cpu_halt,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_dout,
  output logic [7:0]    dma_din,
  output logic          dma_ack,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_dout,
  input  logic [7:0]    mem_din,
  input  logic          mem_dtack,
  output logic          bus_err
);

  localparam int BW = $clog2(DMA_MAX + 1);
  localparam int WW = (TOUT > 1) ? $clog2(TOUT) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(DMA_MAX);
  localparam logic [WW-1:0] WD_LOAD   = WW'(TOUT - 1);

  typedef enum logic [1:0] {IDLE, CPU, DMA, HOLD} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   burst, burst_nxt;
  logic [WW-1:0]   wd, wd_nxt;
  logic            mem_cs_nxt, mem_we_nxt, cpu_ack_nxt, dma_ack_nxt;
  logic            cpu_halt_nxt, bus_err_nxt;
  logic [AW-1:0]   mem_addr_nxt;
  logic [7:0]      mem_dout_nxt, cpu_din_nxt, dma_din_nxt, rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      burst    <= '0;
      wd       <= '0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_dout <= '0;
      cpu_din  <= '0;
      dma_din  <= '0;
      cpu_ack  <= 1'b0;
      dma_ack  <= 1'b0;
      cpu_halt <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      burst    <= burst_nxt;
      wd       <= wd_nxt;
      mem_cs   <= mem_cs_nxt;
      mem_we   <= mem_we_nxt;
      mem_addr <= mem_addr_nxt;
      mem_dout <= mem_dout_nxt;
      cpu_din  <= cpu_din_nxt;
      dma_din  <= dma_din_nxt;
      cpu_ack  <= cpu_ack_nxt;
      dma_ack  <= dma_ack_nxt;
      cpu_halt <= cpu_halt_nxt;
      bus_err  <= bus_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    burst_nxt    = burst;
    wd_nxt       = wd;
    mem_cs_nxt   = mem_cs;
    mem_we_nxt   = mem_we;
    mem_addr_nxt = mem_addr;
    mem_dout_nxt = mem_dout;
    cpu_din_nxt  = cpu_din;
    dma_din_nxt  = dma_din;
    cpu_ack_nxt  = cpu_ack;
    dma_ack_nxt  = dma_ack;
    cpu_halt_nxt = cpu_halt;
    bus_err_nxt  = bus_err;
    rd_data      = 8'hFF;
    if (cen) begin
      cpu_ack_nxt = 1'b0;
      dma_ack_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (dma_req && burst < BURST_MAX) begin
            state_nxt    = HOLD;
            cpu_halt_nxt = 1'b1;
          end else if (cpu_req) begin
            state_nxt    = CPU;
            cpu_halt_nxt = 1'b0;
            mem_cs_nxt   = 1'b1;
            mem_we_nxt   = cpu_we;
            mem_addr_nxt = cpu_addr;
            mem_dout_nxt = cpu_dout;
            wd_nxt       = WD_LOAD;
          end else if (dma_req) begin
            // burst exhausted but nobody else wants the bus: start a new burst
            state_nxt    = HOLD;
            cpu_halt_nxt = 1'b1;
            burst_nxt    = '0;
          end else begin
            cpu_halt_nxt = 1'b0;
            burst_nxt    = '0;
          end
        end
        HOLD: begin
          state_nxt    = DMA;
          mem_cs_nxt   = 1'b1;
          mem_we_nxt   = dma_we;
          mem_addr_nxt = dma_addr;
          mem_dout_nxt = dma_dout;
          wd_nxt       = WD_LOAD;
        end
        CPU, DMA: begin
          if (mem_dtack || wd == '0) begin
            // a watchdog abort completes the access like a normal one,
            // returning 8'hFF and flagging the bus error
            if (mem_dtack) rd_data = mem_din;
            else bus_err_nxt = 1'b1;
            state_nxt  = IDLE;
            mem_cs_nxt = 1'b0;
            mem_we_nxt = 1'b0;
            if (state == CPU) begin
              cpu_din_nxt = rd_data;
              cpu_ack_nxt = 1'b1;
              burst_nxt   = '0;
            end else begin
              dma_din_nxt = rd_data;
              dma_ack_nxt = 1'b1;
              if (burst != BURST_MAX) burst_nxt = burst + BW'(1);
            end
          end else begin
            wd_nxt = wd - WW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkcpu_busarb.sv
`timescale 1ns/1ps
module tb_jtkcpu_busarb;
  localparam int AW      = 24;
  localparam int DMA_MAX = 16;
  localparam int TOUT    = 255;

  logic          clk = 1'b0, rst_n = 1'b0, cen = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [7:0]    cpu_dout = '0, dma_dout = '0, mem_din = '0;
  logic          mem_dtack = 1'b0;
  logic [7:0]    cpu_din, dma_din, mem_dout;
  logic          cpu_ack, cpu_halt, dma_ack, mem_cs, mem_we, bus_err;
  logic [AW-1:0] mem_addr;

  jtkcpu_busarb #(.AW(AW), .DMA_MAX(DMA_MAX), .TOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_halt(cpu_halt),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_dout(dma_dout),
    .dma_din(dma_din), .dma_ack(dma_ack),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_dtack(mem_dtack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cen_div = 1, cen_cnt = 0;
  always @(negedge clk) begin
    cen_cnt = (cen_cnt + 1) % cen_div;
    cen = (cen_cnt == 0);
  end

  task automatic tick();
    do @(posedge clk); while (!cen);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // ---------------- reference memory and scoreboard ----------------
  typedef struct { bit we; int addr; logic [7:0] data; bit abort; } exp_t;
  exp_t cpu_q[$], dma_q[$];
  bit   ack_log[$];
  logic [7:0] ref_mem[int], dev_mem[int];

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 73) ^ (a >> 16) ^ 32'h5A);
  endfunction
  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction
  function automatic logic [7:0] dev_rd(input int a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  // ---------------- memory responder ----------------
  int resp_mode = 0;  // 0: random latency 0..3, 1: fixed resp_lat, 2: never dtack
  int resp_lat  = 0;
  int cs_ticks  = 0;
  initial begin
    int  cnt, lat;
    bit  active;
    cnt = 0; lat = 0; active = 0;
    forever begin
      tick();
      if (!mem_cs) begin
        mem_dtack = 1'b0;
        active    = 0;
      end else begin
        cs_ticks++;
        if (!active) begin
          active = 1;
          cnt    = 0;
          lat    = (resp_mode == 0) ? $urandom_range(0, 3) : resp_lat;
        end else cnt++;
        if (!mem_dtack && resp_mode != 2 && cnt >= lat) begin
          mem_dtack = 1'b1;
          mem_din   = dev_rd(int'(mem_addr));
          if (mem_we) dev_mem[int'(mem_addr)] = mem_dout;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  task automatic check_ack(input bit is_dma, input bit prev);
    exp_t e;
    if (is_dma ? (dma_q.size() == 0) : (cpu_q.size() == 0)) begin
      checks++; failures++;
      $display("FAIL %s_unexpected_ack actual=1 required=0", is_dma ? "dma" : "cpu");
      return;
    end
    e = is_dma ? dma_q.pop_front() : cpu_q.pop_front();
    ack_log.push_back(is_dma);
    check(is_dma ? "dma_ack_pulse" : "cpu_ack_pulse", 32'(prev), 0);
    if (e.we && !e.abort)
      check(is_dma ? "dma_wr_data" : "cpu_wr_data", 32'(dev_rd(e.addr)), 32'(e.data));
    else
      check(is_dma ? "dma_rd_data" : "cpu_rd_data", 32'(is_dma ? dma_din : cpu_din), 32'(e.data));
    check(is_dma ? "dma_ack_halt" : "cpu_ack_halt", 32'(cpu_halt), 32'(is_dma));
  endtask

  initial begin
    bit prev_c, prev_d;
    prev_c = 0; prev_d = 0;
    forever begin
      tick();
      if (cpu_ack && dma_ack) check("ack_exclusive", 32'({cpu_ack, dma_ack}), 32'b01);
      if (cpu_ack) check_ack(0, prev_c);
      if (dma_ack) check_ack(1, prev_d);
      prev_c = cpu_ack;
      prev_d = dma_ack;
    end
  end

  // ---------------- outputs must hold on cen=0 edges ----------------
  localparam int OW = AW + 30;
  logic [OW-1:0] outs, snap;
  assign outs = {mem_cs, mem_we, mem_addr, mem_dout, cpu_din, dma_din,
                 cpu_ack, dma_ack, cpu_halt, bus_err};
  bit hold_en = 0;
  int hold_errs = 0, hold_samples = 0;
  always @(negedge clk) snap = outs;
  always @(posedge clk) begin
    if (hold_en && rst_n && !cen) begin
      #1;
      hold_samples++;
      if (outs !== snap) hold_errs++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(input bit is_dma, input bit we, input int addr,
                        input logic [7:0] data, input bit abort, output int lat);
    exp_t e;
    e.we = we; e.addr = addr; e.abort = abort;
    if (abort) e.data = 8'hFF;
    else if (we) begin e.data = data; ref_mem[addr] = data; end
    else e.data = ref_rd(addr);
    if (is_dma) begin
      dma_q.push_back(e);
      dma_we = we; dma_addr = AW'(addr); dma_dout = data; dma_req = 1'b1;
    end else begin
      cpu_q.push_back(e);
      cpu_we = we; cpu_addr = AW'(addr); cpu_dout = data; cpu_req = 1'b1;
    end
    lat = 0;
    do begin tick(); lat++; end while (!(is_dma ? dma_ack : cpu_ack) && lat < 2000);
    check(is_dma ? "dma_ack_seen" : "cpu_ack_seen", 32'(is_dma ? dma_ack : cpu_ack), 1);
    if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
  endtask

  function automatic int cpu_a();
    return 32'h120000 | int'($urandom_range(0, 31));
  endfunction
  function automatic int dma_a();
    return 32'hA50000 | int'($urandom_range(0, 31));
  endfunction

  task automatic traffic(input int n);
    fork
      for (int i = 0; i < n; i++) begin
        int l;
        repeat ($urandom_range(0, 3)) tick();
        access(0, 1'($urandom), cpu_a(), 8'($urandom), 0, l);
      end
      for (int j = 0; j < n; j++) begin
        int l;
        repeat ($urandom_range(0, 3)) tick();
        access(1, 1'($urandom), dma_a(), 8'($urandom), 0, l);
      end
    join
  endtask

  task automatic cpu_read_lat2();
    int l;
    resp_mode = 1; resp_lat = 2; cs_ticks = 0;
    access(0, 0, cpu_a(), 8'h00, 0, l);
    check("cpu_rd_latency", 32'(l), 4);
    check("cpu_rd_cs_ticks", 32'(cs_ticks), 3);
  endtask

  initial begin
    int l, da, cpu_pos;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({mem_cs, mem_we, cpu_ack, dma_ack, cpu_halt, bus_err}), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_data", 32'({mem_dout, cpu_din, dma_din}), 0);
    rst_n = 1'b1;
    hold_en = 1;
    repeat (4) tick();

    cpu_read_lat2();

    // simultaneous requests with an empty burst: DMA goes first through HOLD
    repeat (3) tick();
    resp_mode = 1; resp_lat = 0;
    ack_log.delete();
    da = dma_a();
    fork
      access(0, 0, cpu_a(), 8'h00, 0, l);
      begin int l2; access(1, 0, da, 8'h00, 0, l2); end
      begin
        tick();
        check("hold_halt", 32'(cpu_halt), 1);
        check("hold_cs", 32'(mem_cs), 0);
        tick();
        check("dma_first_addr", 32'(mem_addr), 32'(da));
      end
    join
    check("dma_first_count", 32'(ack_log.size()), 2);
    if (ack_log.size() > 0) check("dma_first_order", 32'(ack_log[0]), 1);

    // DMA holds its request for 20 accesses; CPU must get in after DMA_MAX
    repeat (3) tick();
    resp_mode = 0;
    ack_log.delete();
    fork
      for (int i = 0; i < 20; i++) begin
        int l3;
        access(1, 1'($urandom), dma_a(), 8'($urandom), 0, l3);
      end
      begin int l4; access(0, 0, cpu_a(), 8'h00, 0, l4); end
    join
    cpu_pos = -1;
    foreach (ack_log[k]) if (!ack_log[k] && cpu_pos < 0) cpu_pos = k;
    check("burst_cpu_slot", 32'(cpu_pos), DMA_MAX);
    check("burst_total", 32'(ack_log.size()), 21);

    resp_mode = 0;
    traffic(30);

    cen_div = 4;
    repeat (4) tick();
    cpu_read_lat2();
    resp_mode = 0;
    traffic(15);
    cen_div = 1;
    repeat (4) tick();

    // watchdog: dtack never comes
    resp_mode = 2; cs_ticks = 0;
    check("bus_err_before", 32'(bus_err), 0);
    access(0, 0, cpu_a(), 8'h00, 1, l);
    check("wd_latency", 32'(l), TOUT + 1);
    check("wd_cs_ticks", 32'(cs_ticks), TOUT);
    check("wd_bus_err", 32'(bus_err), 1);
    resp_mode = 1; resp_lat = 0;
    access(1, 0, dma_a(), 8'h00, 0, l);
    check("bus_err_sticky", 32'(bus_err), 1);

    // reset in the middle of a DMA write
    repeat (2) tick();
    resp_mode = 2;
    dma_we = 1'b1; dma_addr = AW'(dma_a()); dma_dout = 8'h3C; dma_req = 1'b1;
    tick(); tick();
    check("dma_wr_active", 32'({mem_cs, mem_we, cpu_halt}), 32'b111);
    hold_en = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", 32'({mem_cs, mem_we, cpu_halt}), 0);
    check("rst_bus_err", 32'(bus_err), 0);
    dma_req = 1'b0; dma_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    hold_en = 1;
    resp_mode = 1; resp_lat = 0;
    access(0, 0, cpu_a(), 8'h00, 0, l);
    check("post_rst_latency", 32'(l), 2);
    repeat (4) tick();

    check("cen_hold_seen", 32'(hold_samples > 0), 1);
    check("cen_hold", 32'(hold_errs), 0);
    check("scoreboard_empty", 32'(cpu_q.size() + dma_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
